image_stream_reader: RTL and testbench

Parametrised successor to the single-word image reader: streams a runtime-selected window of words from a synchronous-read BRAM onto an AXI-Stream master at up to one beat per cycle. Reads are pipelined against a configurable BRAM read latency and buffered in a small output FIFO, so downstream backpressure never drops or duplicates data. Supports a partial final word via `tkeep` and a synchronous abort. Sits between the image BRAM and the AES encryptor input.

---
 rtl/image_stream_pkg.sv | 28 ++
 rtl/stream_fifo.sv | 61 ++++++
 rtl/image_stream_reader.sv | 180 ++++++++++++++++++
 tb/tb_image_stream_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/image_stream_pkg.sv
// Shared types and helpers for the image stream reader: FSM states and the
// byte-enable mask of a partial final word.
package image_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int MAX_KEEP = 64;

  // Low last_bytes lanes set; zero means the whole word is valid.
  function automatic logic [MAX_KEEP-1:0] keep_mask(input logic [7:0] last_bytes);
    logic [MAX_KEEP-1:0] mask;
    mask = {MAX_KEEP{1'b1}};
    if (last_bytes != 8'd0) begin
      for (int i = 0; i < MAX_KEEP; i++) begin
        mask[i] = (i < int'(last_bytes));
      end
    end else begin
      mask = {MAX_KEEP{1'b1}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO whose head entry is always presented on rd_data_o; a
// write and a read may share an edge even when full. flush empties it.
module stream_fifo #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             push_s, pop_s;

  assign empty_o   = (count_q == {(PW+1){1'b0}});
  assign full_o    = (count_q == (PW+1)'(DEPTH));
  assign pop_s     = rd_en_i && !empty_o;
  assign push_s    = wr_en_i && (!full_o || pop_s);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_VAL;
      end
    end else if (flush_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (PW+1)'(1'b1);
        2'b01:   count_q <= count_q - (PW+1)'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/image_stream_reader.sv
// Streams a window of BRAM words onto an AXI-Stream master. Reads are issued
// only while in-flight reads plus buffered beats leave room in the output FIFO.
module image_stream_reader
  import image_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [LEN_WIDTH-1:0]            num_words,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] last_bytes,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_WIDTH-1:0]           bram_addr,
  output logic                            bram_en,
  input  logic [DATA_WIDTH-1:0]           bram_dout,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]         m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready
);
  localparam int KEEP_W  = DATA_WIDTH / 8;
  localparam int LB_W    = $clog2(KEEP_W);
  localparam int ENTRY_W = 1 + KEEP_W + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [LEN_WIDTH-1:0]   num_q, num_d, issued_q, issued_d;
  logic [LB_W-1:0]        lb_q, lb_d;
  logic                   done_q, done_d;
  logic [RD_LATENCY-1:0]  vld_q, last_pipe_q;
  logic [KEEP_W-1:0]      keep_pipe_q [RD_LATENCY];
  logic [CNT_W-1:0]       inflight_s, fifo_count_s;
  logic                   fifo_full_s, fifo_empty_s;
  logic                   credit_s, issue_s, is_last_s, last_hs_s, flush_s;
  logic [KEEP_W-1:0]      issue_keep_s;
  logic [ENTRY_W-1:0]     fifo_rd_s;

  assign is_last_s    = (issued_q == (num_q - LEN_WIDTH'(1'b1)));
  assign issue_keep_s = is_last_s ? KEEP_W'(keep_mask(8'(lb_q))) : {KEEP_W{1'b1}};
  assign credit_s     = !fifo_full_s && ((inflight_s + fifo_count_s) < CNT_W'(FIFO_DEPTH));
  assign issue_s      = (state_q == ST_RUN) && !abort && credit_s;
  assign flush_s      = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign last_hs_s    = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  assign bram_en   = issue_s;
  assign bram_addr = base_q + ADDR_WIDTH'(issued_q);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign m_axis_tvalid = !fifo_empty_s;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_rd_s;

  always_comb begin
    inflight_s = {CNT_W{1'b0}};
    for (int k = 0; k < RD_LATENCY; k++) begin
      inflight_s = inflight_s + CNT_W'(vld_q[k]);
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    num_d    = num_q;
    lb_d     = lb_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = num_words;
          lb_d     = last_bytes;
          issued_d = {LEN_WIDTH{1'b0}};
          if (num_words == {LEN_WIDTH{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (issue_s) begin
          issued_d = issued_q + LEN_WIDTH'(1'b1);
          state_d  = is_last_s ? ST_DRAIN : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_hs_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // An empty transfer has no tlast handshake, so its pulse follows DONE.
        done_d  = (num_q == {LEN_WIDTH{1'b0}});
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      base_q   <= {ADDR_WIDTH{1'b0}};
      num_q    <= {LEN_WIDTH{1'b0}};
      lb_q     <= {LB_W{1'b0}};
      issued_q <= {LEN_WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      num_q    <= num_d;
      lb_q     <= lb_d;
      issued_q <= issued_d;
      done_q   <= done_d;
    end
  end

  // tlast/tkeep travel alongside each read so they meet its data at the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= {RD_LATENCY{1'b0}};
      last_pipe_q <= {RD_LATENCY{1'b0}};
      for (int k = 0; k < RD_LATENCY; k++) begin
        keep_pipe_q[k] <= {KEEP_W{1'b0}};
      end
    end else if (flush_s) begin
      vld_q <= {RD_LATENCY{1'b0}};
    end else begin
      for (int k = RD_LATENCY - 1; k > 0; k--) begin
        vld_q[k]       <= vld_q[k-1];
        last_pipe_q[k] <= last_pipe_q[k-1];
        keep_pipe_q[k] <= keep_pipe_q[k-1];
      end
      vld_q[0]       <= issue_s;
      last_pipe_q[0] <= is_last_s;
      keep_pipe_q[0] <= issue_keep_s;
    end
  end

  stream_fifo #(
    .WIDTH   (ENTRY_W),
    .DEPTH   (FIFO_DEPTH),
    .RST_VAL ({1'b0, {KEEP_W{1'b1}}, {DATA_WIDTH{1'b0}}})
  ) u_fifo (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .flush_i   (flush_s),
    .wr_en_i   (vld_q[RD_LATENCY-1]),
    .wr_data_i ({last_pipe_q[RD_LATENCY-1], keep_pipe_q[RD_LATENCY-1], bram_dout}),
    .rd_en_i   (m_axis_tready),
    .rd_data_o (fifo_rd_s),
    .count_o   (fifo_count_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

endmodule

// File: tb/tb_image_stream_reader.sv
// Bench for image_stream_reader: a transfer-level model checks the
// RD_LATENCY=1 instance every cycle; a RD_LATENCY=3 instance is checked directly.
module tb_image_stream_reader;
  localparam int DW = 128;
  localparam int AW = 10;
  localparam int LW = 11;
  localparam int KW = 16;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, abort = 1'b0, tready = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LW-1:0] nw = '0;
  logic [BW-1:0] lb = '0;

  logic          busy1, done1, en1, tv1, tl1, busy3, done3, en3, tv3, tl3;
  logic [AW-1:0] addr1, addr3;
  logic [DW-1:0] dout1, td1, dout3, td3;
  logic [KW-1:0] tk1, tk3;

  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] p1;
  logic [DW-1:0] p3 [3];
  int cyc = 0;
  int n_chk = 0, n_pass = 0;

  image_stream_reader dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base),
    .num_words(nw), .last_bytes(lb), .busy(busy1), .done(done1), .bram_addr(addr1),
    .bram_en(en1), .bram_dout(dout1), .m_axis_tdata(td1), .m_axis_tkeep(tk1),
    .m_axis_tlast(tl1), .m_axis_tvalid(tv1), .m_axis_tready(tready));

  image_stream_reader #(.RD_LATENCY(3), .FIFO_DEPTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base),
    .num_words(nw), .last_bytes(lb), .busy(busy3), .done(done3), .bram_addr(addr3),
    .bram_en(en3), .bram_dout(dout3), .m_axis_tdata(td3), .m_axis_tkeep(tk3),
    .m_axis_tlast(tl3), .m_axis_tvalid(tv3), .m_axis_tready(tready));

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) p1 <= en1 ? mem[addr1] : '0;
  always @(posedge clk) begin
    p3[0] <= en3 ? mem[addr3] : '0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign dout1 = p1;
  assign dout3 = p3[2];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic l; } beat_t;
  beat_t exp_q[$];
  int    addr_log[$];
  logic [DW-1:0] d3_data[$];
  bit    active = 0, hs_last_prev = 0, expect_tv0 = 0;
  int    zero_cd = 0, n_iss = 0, n_hs = 0, cur_n = 0, cur_base = 0;
  int    m_t0 = 0, m_first_tv = -1, m_done_cyc = -1, m_beats = 0;
  logic [KW-1:0] m_last_keep = '0;
  int    t0 = 0, d3_first = -1, d3_done = -1;

  // Transfer-level model of dut1, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); active = 0; hs_last_prev = 0; expect_tv0 = 0; zero_cd = 0;
    end else begin
      chk("done", done1, hs_last_prev || (zero_cd == 1));
      if (done1) m_done_cyc = cyc - m_t0;
      if (hs_last_prev) active = 0;
      hs_last_prev = 0;
      if (zero_cd > 0) zero_cd--;
      if (expect_tv0) begin
        chk("tvalid_after_abort", tv1, 0);
        chk("busy_after_abort", busy1, 0);
        expect_tv0 = 0;
      end
      if (start && !active && zero_cd == 0) begin
        m_t0 = cyc; m_first_tv = -1; m_done_cyc = -1; m_beats = 0;
        n_iss = 0; n_hs = 0; addr_log.delete(); exp_q.delete();
        cur_base = int'(base); cur_n = int'(nw);
        if (nw == 0) zero_cd = 2;
        else begin
          active = 1;
          for (int i = 0; i < cur_n; i++) begin
            beat_t b;
            b.d = mem[(cur_base + i) % 1024];
            b.l = (i == cur_n - 1);
            b.k = (b.l && lb != 0) ? KW'((17'd1 << lb) - 17'd1) : 16'hFFFF;
            exp_q.push_back(b);
          end
        end
      end else if (abort && active) begin
        chk("no_issue_on_abort", en1, 0);
        exp_q.delete(); active = 0; expect_tv0 = 1;
      end else begin
        if (en1) begin
          addr_log.push_back(int'(addr1));
          chk("read_allowed", active && n_iss < cur_n, 1);
          chk("rd_addr", addr1, DW'((cur_base + n_iss) % 1024));
          chk("credit", (n_iss - n_hs) < 4, 1);
          n_iss++;
        end
        if (tv1) begin
          if (m_first_tv < 0) m_first_tv = cyc - m_t0;
          chk("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            chk("tdata", td1, exp_q[0].d);
            chk("tkeep", tk1, exp_q[0].k);
            chk("tlast", tl1, exp_q[0].l);
            if (tready) begin
              hs_last_prev = exp_q[0].l;
              m_last_keep = tk1;
              void'(exp_q.pop_front());
              n_hs++; m_beats++;
            end
          end
        end
      end
    end
  end

  // Observation of the RD_LATENCY=3 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tv3 && d3_first < 0) d3_first = cyc - t0;
      if (tv3 && tready) d3_data.push_back(td3);
      if (done3) d3_done = cyc - t0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_xfer(input int b, input int n, input int l);
    base = AW'(b); nw = LW'(n); lb = BW'(l);
    t0 = cyc; d3_first = -1; d3_done = -1; d3_data.delete();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int budget = 300;
    while ((busy1 || busy3 || tv1 || tv3) && budget > 0) begin step(1); budget--; end
    chk({name, "_idle_in_time"}, budget > 0, 1);
    step(3);
  endtask

  logic [39:0] pat = 40'b1011_0010_1101_0011_1000_1110_0101_1011_0110_1001;

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = {32'hC0DE0000 + 32'(i), 32'(i * 7), ~32'(i), 32'(i) ^ 32'h5A5A5A5A};
    step(2);
    chk("rst_busy", busy1, 0); chk("rst_done", done1, 0); chk("rst_en", en1, 0);
    chk("rst_tvalid", tv1, 0); chk("rst_tlast", tl1, 0); chk("rst_addr", addr1, 0);
    chk("rst_tdata", td1, 0); chk("rst_tkeep", tk1, 16'hFFFF);
    rst_n = 1'b1;
    step(2);

    // Full rate at both latencies.
    tready = 1'b1;
    start_xfer(0, 4, 0);
    wait_idle("t1");
    chk("t1_first_tvalid", m_first_tv, 3);
    chk("t1_done_cycle", m_done_cyc, 7);
    chk("t1_beats", m_beats, 4);
    chk("t1_keep", m_last_keep, 16'hFFFF);
    chk("l3_first_tvalid", d3_first, 5);
    chk("l3_done_cycle", d3_done, 9);
    chk("l3_beats", d3_data.size(), 4);
    for (int i = 0; i < 4 && i < d3_data.size(); i++) chk("l3_data", d3_data[i], mem[i]);

    // Backpressure.
    start_xfer(16, 8, 0);
    for (int k = 0; k < 40 && (busy1 || busy3); k++) begin tready = pat[k]; step(1); end
    tready = 1'b1;
    wait_idle("t2");
    chk("t2_beats", m_beats, 8);
    chk("t2_l3_beats", d3_data.size(), 8);

    // Partial last word with address wrap.
    start_xfer(1022, 3, 5);
    wait_idle("t3");
    chk("t3_reads", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      chk("t3_addr0", addr_log[0], 1022);
      chk("t3_addr1", addr_log[1], 1023);
      chk("t3_addr2", addr_log[2], 0);
    end
    chk("t3_last_keep", m_last_keep, 16'h001F);

    // Zero length.
    start_xfer(7, 0, 0);
    wait_idle("t4");
    chk("t4_done_cycle", m_done_cyc, 2);
    chk("t4_no_reads", addr_log.size(), 0);
    chk("t4_no_tvalid", m_first_tv, -1);

    // Abort after two beats with the sink stalled.
    start_xfer(200, 16, 0);
    for (int k = 0; k < 100 && m_beats < 2; k++) step(1);
    tready = 1'b0;
    chk("t5_two_beats", m_beats, 2);
    step(3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t5_tvalid_low", tv1, 0);
    chk("t5_busy_low", busy1, 0);
    step(3);
    chk("t5_no_done", m_done_cyc, -1);
    tready = 1'b1;
    abort = 1'b1;
    start_xfer(300, 2, 0);
    abort = 1'b0;
    wait_idle("t5b");
    chk("t5_restart_beats", m_beats, 2);
    chk("t5_restart_done", m_done_cyc, 5);

    // Reset mid-transfer, then recovery.
    start_xfer(0, 16, 0);
    step(6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy1, 0); chk("mid_rst_en", en1, 0); chk("mid_rst_tvalid", tv1, 0);
    chk("mid_rst_tlast", tl1, 0); chk("mid_rst_addr", addr1, 0); chk("mid_rst_tdata", td1, 0);
    chk("mid_rst_tkeep", tk1, 16'hFFFF); chk("mid_rst_done", done1, 0);
    chk("mid_rst_tvalid3", tv3, 0); chk("mid_rst_busy3", busy3, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    start_xfer(5, 3, 0);
    wait_idle("t6");
    chk("t6_beats", m_beats, 3);
    chk("t6_done_cycle", m_done_cyc, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
